multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit that sequences each RV32I instruction through FETCH, DECODE, EXEC, MEM and WB states. It drives the 4-bit `alu_op` code consumed by the `alu` block, plus all datapath select lines and write strobes. Memory accesses use a req/ready handshake, so instruction and data memories may stall for any number of cycles. The block sits beside the datapath in the multi-cycle processor and replaces the single-cycle combinational control.

## Interface
Parameters:
- `RESET_TO_TRAP`, 0, when 1 an illegal opcode also asserts `illegal` on the reset-exit cycle (verification hook only; tie 0 in product).

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `instr`  in  32  instruction register contents; stable from DECODE until the next FETCH handshake
- `alu_zero`  in  1  ALU result == 0, combinational from the datapath
- `mem_ready`  in  1  memory completes the current request this cycle
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = store, 0 = read
- `addr_sel`  out  1  memory address select: 0 = PC, 1 = ALU result register
- `ir_we`  out  1  capture fetched word into IR
- `alu_op`  out  4  ALU operation code
- `alu_src_a`  out  2  ALU A select: 0 = rs1, 1 = PC, 2 = zero
- `alu_src_b`  out  1  ALU B select: 0 = rs2, 1 = immediate
- `reg_we`  out  1  register file write strobe
- `wb_sel`  out  2  writeback select: 0 = ALU result register, 1 = memory data, 2 = PC+4
- `pc_we`  out  1  PC write strobe
- `pc_sel`  out  2  next-PC select: 0 = PC+4, 1 = ALU result register, 2 = PC+imm (branch adder)
- `illegal`  out  1  sticky illegal-instruction flag

## Operation
- ALU op codes: ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
- ALU decode by instruction class:
  - R-type (0110011): `alu_op = {funct3, funct7[5]}`.
  - I-ALU (0010011): `{funct3, funct7[5]}` when funct3 = 101, else `{funct3, 0}`. ADDI therefore never becomes SUB.
  - LOAD, STORE, JAL, JALR, LUI, AUIPC: ADD.
  - BEQ/BNE: SUB. BLT/BGE: SLT. BLTU/BGEU: SLTU.
- FETCH: `mem_req=1`, `addr_sel=0`, `mem_we=0`. Hold until `mem_ready`; in that cycle `ir_we=1`, then go to DECODE.
- DECODE: one cycle, no strobes. An unknown opcode, or branch funct3 010/011, sets `illegal` and goes to TRAP. Otherwise go to EXEC.
- EXEC: `alu_op`, `alu_src_a`, `alu_src_b` driven per class.
  - AUIPC and JAL use src_a = PC. LUI uses src_a = zero. All others use rs1.
  - Branch: src_b = rs2, `pc_we=1`. `pc_sel=2` if taken, else 0. Go to FETCH.
  - Taken when: BEQ/BGE/BGEU `alu_zero=1`; BNE/BLT/BLTU `alu_zero=0`.
  - LOAD/STORE go to MEM. All other classes go to WB.
- MEM: `mem_req=1`, `addr_sel=1`, `mem_we` = store. Hold until `mem_ready`.
  - Store: on the ready cycle `pc_we=1`, `pc_sel=0`, go to FETCH.
  - Load: go to WB.
- WB: `reg_we=1`, `pc_we=1`, then go to FETCH.
  - `wb_sel`: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - `pc_sel`: 1 for JAL/JALR, 0 otherwise.
- TRAP: all strobes 0; held until `rst`.

## Timing
- Reset:
  - While `rst`=1 at a clock edge, the state becomes FETCH and `illegal` clears.
  - During the `rst`=1 cycles all outputs are 0: `mem_req`, `ir_we`, `reg_we`, `pc_we`, `mem_we`, `illegal`, and all selects.
  - First cycle after release: FETCH with `mem_req=1`.
- Outputs are Moore (state + stable `instr`). Exception: `ir_we` and the MEM-state store `pc_we` are qualified by `mem_ready`, and the branch `pc_sel` by `alu_zero`.
- Latency with zero-wait memory:
  - branch 3 cycles, store 4 cycles, ALU/LUI/AUIPC/JAL/JALR 4 cycles, load 5 cycles.
  - Each wait cycle adds 1.
- `mem_req` and `addr_sel` stay constant while waiting. `mem_ready` is ignored outside FETCH/MEM.
- `rst` asserted mid-MEM abandons the access; no `reg_we` or `pc_we` is issued.
- At most one of `reg_we`, `ir_we` is high in any cycle, and each is high for exactly one cycle per instruction.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP);
  - `alu_op` localparams;
  - RV32I opcode constants;
  - the `alu_src_a`, `wb_sel` and `pc_sel` encodings.
- Sub-module `alu_decoder` (combinational): opcode, funct3, funct7[5] → `alu_op`. It is reusable by the single-cycle core.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) with `mem_ready`=1:
  - FETCH, DECODE, EXEC (`alu_op`=0000) then WB (`reg_we`=1, `wb_sel`=0, `pc_we`=1, `pc_sel`=0).
  - Total 4 cycles.
- `sub` (0x402081B3) → `alu_op`=0001. `srai x1,x1,3` (0x4030D093) → 1011. `addi x1,x0,-1` (0xFFF00093) → 0000, never 0001.
- `beq x1,x2,+8` (0x00208463):
  - `alu_zero`=1 in EXEC → `pc_we`=1, `pc_sel`=2.
  - Repeat with `alu_zero`=0 → `pc_sel`=0. Both cases take 3 cycles.
- `lw x5,0(x1)` (0x0000A283) with `mem_ready` low for 2 cycles in FETCH and 3 in MEM:
  - `mem_req` held with `addr_sel` 0 then 1.
  - WB `wb_sel`=1. Total 10 cycles.
- `sw` (0x0050A023): MEM has `mem_we`=1, and `pc_we` fires only in the `mem_ready` cycle. Assert `rst` mid-wait → no `pc_we`, and FETCH follows.
- Opcode 0x7F (0xFFFFFFFF) → TRAP, `illegal`=1 held for 20 cycles with no strobes. `rst` clears it.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states,
// ALU op codes, opcodes and datapath select values.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1110;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_ALU    = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;

  function automatic logic opcode_legal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Instruction-class to ALU op mapping; purely combinational so the
// single-cycle core can share it.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_op_o
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_op_o = ALU_ADD;
    case (opcode_i)
      OPC_OP:     alu_op_o = {funct3_i, funct7_5_i};
      // Only the shift-right group uses funct7[5] for immediates, so ADDI never turns into SUB.
      OPC_OP_IMM: alu_op_o = {funct3_i, (funct3_i == 3'b101) ? funct7_5_i : 1'b0};
      OPC_BRANCH: begin
        case (funct3_i[2:1])
          2'b00:   alu_op_o = ALU_SUB;
          2'b10:   alu_op_o = ALU_SLT;
          2'b11:   alu_op_o = ALU_SLTU;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      default:    alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with req/ready
// memory handshakes and a sticky illegal-instruction trap.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit RESET_TO_TRAP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        illegal
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   rst_exit_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_op;
  logic       instr_bad, branch_taken;
  logic [3:0] dec_alu_op;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_op     = (opcode == OPC_OP);

  assign instr_bad = !opcode_legal(opcode) || (is_branch && (funct3[2:1] == 2'b01));

  // BEQ/BGE/BGEU are taken on a zero ALU result, BNE/BLT/BLTU on non-zero.
  assign branch_taken = (alu_zero == ~(funct3[2] ^ funct3[0]));

  alu_decoder u_alu_decoder (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7_5_i (instr[30]),
    .alu_op_o   (dec_alu_op)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      illegal_q  <= 1'b0;
      rst_exit_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      illegal_q  <= illegal_d;
      rst_exit_q <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    alu_op    = ALU_ADD;
    alu_src_a = SRC_A_RS1;
    alu_src_b = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    illegal   = 1'b0;

    // Outputs are forced quiet while rst is high, which also abandons a pending access.
    if (!rst) begin
      illegal = illegal_q || (RESET_TO_TRAP && rst_exit_q && instr_bad);
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          if (instr_bad) begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end else begin
            state_d   = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_op    = dec_alu_op;
          alu_src_a = (is_auipc || is_jal) ? SRC_A_PC : (is_lui ? SRC_A_ZERO : SRC_A_RS1);
          alu_src_b = !(is_op || is_branch);
          if (is_branch) begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? PC_BRANCH : PC_PLUS4;
            state_d = S_FETCH;
          end else if (is_load || is_store) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = is_store;
          if (mem_ready) begin
            if (is_store) begin
              pc_we   = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          reg_we  = 1'b1;
          pc_we   = 1'b1;
          wb_sel  = is_load ? WB_MEM : ((is_jal || is_jalr) ? WB_PC4 : WB_ALU);
          pc_sel  = (is_jal || is_jalr) ? PC_ALU : PC_PLUS4;
          state_d = S_FETCH;
        end
        S_TRAP:  state_d = S_TRAP;
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: a per-instruction phase model queues the expected output
// vector of every cycle; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, alu_src_b, reg_we, pc_we, illegal;
  logic [3:0]  alu_op;
  logic [1:0]  alu_src_a, wb_sel, pc_sel;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_TO_TRAP(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_we     (ir_we),
    .alu_op    (alu_op),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .illegal   (illegal)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic [3:0] alu_op;
    logic [1:0] src_a;
    logic       src_b;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       illegal;
  } vec_t;

  typedef struct {
    vec_t  v;
    string tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  vec_t act_v;

  assign act_v = {mem_req, mem_we, addr_sel, ir_we, alu_op, alu_src_a, alu_src_b,
                  reg_we, wb_sel, pc_we, pc_sel, illegal};

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BR = 7'h63;
  localparam logic [6:0] LD = 7'h03, ST = 7'h23, OPI = 7'h13, OPR = 7'h33;
  logic [6:0] legal_opc [9] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR};
  logic [2:0] br_f3 [6]     = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  task automatic check(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %05h expected %05h (mem_req,we,addr,ir,aluop,srca,srcb,reg,wb,pcwe,pcsel,ill)",
               name, act, exp);
    end
  endtask

  // Monitor: one expected vector per clock, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.tag, act_v, e.v);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] ref_alu(input logic [31:0] i);
    logic [2:0] f3 = i[14:12];
    case (i[6:0])
      OPR: return {f3, i[30]};
      OPI: return (f3 == 3'd5) ? {f3, i[30]} : {f3, 1'b0};
      BR: begin
        case (f3)
          3'd0, 3'd1: return 4'b0001;
          3'd4, 3'd5: return 4'b0100;
          default:    return 4'b0110;
        endcase
      end
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic z);
    case (f3)
      3'd0, 3'd5, 3'd7: return z;
      default:          return !z;
    endcase
  endfunction

  function automatic logic ref_bad(input logic [31:0] i);
    logic hit = 1'b0;
    for (int k = 0; k < 9; k++) if (i[6:0] == legal_opc[k]) hit = 1'b1;
    if (i[6:0] == BR && (i[14:12] == 3'd2 || i[14:12] == 3'd3)) hit = 1'b0;
    return !hit;
  endfunction

  task automatic cyc(input logic r, input logic [31:0] ins, input logic z, input logic rdy,
                     input vec_t v, input string tag);
    exp_t e;
    rst       = r;
    instr     = ins;
    alu_zero  = z;
    mem_ready = rdy;
    e.v       = v;
    e.tag     = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, $urandom, rbit(), rbit(), '0, "reset");
  endtask

  // Phase model of one instruction; abort_at >= 0 raises rst in that MEM cycle.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z,
                           input int abort_at);
    vec_t  v;
    logic [6:0] opc = ins[6:0];
    logic  ld  = (opc == LD);
    logic  st  = (opc == ST);
    logic  br  = (opc == BR);
    logic  jmp = (opc == JAL) || (opc == JALR);
    string nm  = $sformatf("%08h", ins);

    for (int k = 0; k <= fw; k++) begin
      v = '0;
      v.mem_req = 1'b1;
      v.ir_we   = (k == fw);
      cyc(1'b0, $urandom, rbit(), (k == fw), v, {nm, " fetch"});
    end
    cyc(1'b0, ins, rbit(), rbit(), '0, {nm, " decode"});
    if (ref_bad(ins)) begin
      for (int k = 0; k < 20; k++) begin
        v = '0;
        v.illegal = 1'b1;
        cyc(1'b0, ins, rbit(), rbit(), v, {nm, " trap"});
      end
      return;
    end

    v = '0;
    v.alu_op = ref_alu(ins);
    v.src_a  = (opc == AUIPC || opc == JAL) ? 2'd1 : ((opc == LUI) ? 2'd2 : 2'd0);
    v.src_b  = !(opc == OPR || br);
    if (br) begin
      v.pc_we  = 1'b1;
      v.pc_sel = ref_taken(ins[14:12], z) ? 2'd2 : 2'd0;
    end
    cyc(1'b0, ins, z, rbit(), v, {nm, " exec"});
    if (br) return;

    if (ld || st) begin
      for (int k = 0; k <= mw; k++) begin
        if (k == abort_at) begin
          cyc(1'b1, ins, rbit(), 1'b1, '0, {nm, " rst mid-mem"});
          return;
        end
        v = '0;
        v.mem_req  = 1'b1;
        v.addr_sel = 1'b1;
        v.mem_we   = st;
        v.pc_we    = st && (k == mw);
        cyc(1'b0, ins, rbit(), (k == mw), v, {nm, " mem"});
      end
      if (st) return;
    end

    v = '0;
    v.reg_we = 1'b1;
    v.pc_we  = 1'b1;
    v.wb_sel = ld ? 2'd1 : (jmp ? 2'd2 : 2'd0);
    v.pc_sel = jmp ? 2'd1 : 2'd0;
    cyc(1'b0, ins, rbit(), rbit(), v, {nm, " wb"});
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] i = $urandom;
    i[6:0] = legal_opc[$urandom_range(0, 8)];
    if (i[6:0] == BR) i[14:12] = br_f3[$urandom_range(0, 5)];
    return i;
  endfunction

  initial begin
    do_reset(2);
    run_instr(32'h002081B3, 0, 0, 1'b0, -1);  // add
    run_instr(32'h402081B3, 0, 0, 1'b1, -1);  // sub
    run_instr(32'h4030D093, 0, 0, 1'b0, -1);  // srai
    run_instr(32'hFFF00093, 0, 0, 1'b1, -1);  // addi -1
    run_instr(32'h00208463, 0, 0, 1'b1, -1);  // beq taken
    run_instr(32'h00208463, 0, 0, 1'b0, -1);  // beq not taken
    run_instr(32'h0000A283, 2, 3, 1'b0, -1);  // lw with waits
    run_instr(32'h0050A023, 1, 2, 1'b0, -1);  // sw with waits
    run_instr(32'h0050A023, 0, 4, 1'b0, 2);   // sw abandoned by rst
    for (int n = 0; n < 80; n++)
      run_instr(rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3), rbit(), -1);
    run_instr(32'hFFFFFFFF, 1, 0, 1'b0, -1);  // unknown opcode
    do_reset(1);
    run_instr(32'h0020A463, 0, 0, 1'b0, -1);  // branch funct3 010
    do_reset(2);
    run_instr(32'h002081B3, 0, 0, 1'b0, -1);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
